// File: rtl/vmem_arbiter.sv
// Arbiter that shares one synchronous virtual-memory RAM between the processor
// and the display/input peripheral, and routes read returns back to their owner.
//
// Ports:
//   system_clock, reset                  - single clock, async active-high reset
//   cpu_wren/cpu_address/cpu_data        - processor access, issued every cycle
//   cpu_q                                - processor read data (cycle after read)
//   cpu_hold                             - processor access dropped this cycle
//   per_req/per_wren/per_address/per_data- peripheral request, held until per_gnt
//   per_gnt                              - peripheral request issued to RAM
//   per_rvalid/per_q                     - peripheral read return
//   mem_wren/mem_address/mem_data/mem_q  - RAM port, one-cycle read latency
//   stall_count                          - saturating count of cpu_hold cycles
module vmem_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CPU_BASE   = 5000,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              system_clock,
  input  logic              reset,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_hold,
  input  logic              per_req,
  input  logic              per_wren,
  input  logic [ADDR_W-1:0] per_address,
  input  logic [DATA_W-1:0] per_data,
  output logic              per_gnt,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_q,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic [15:0]       stall_count
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_SAT = '1;

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_PER} owner_t;
  typedef enum logic [1:0] {RTAG_NONE, RTAG_CPU, RTAG_PER} rtag_t;

  owner_t               owner;
  rtag_t                rtag;
  rtag_t                rtag_nxt;
  logic [CNT_W-1:0]     starve_cnt;
  logic [CNT_W-1:0]     starve_nxt;
  logic [STALL_W-1:0]   stall_nxt;
  logic                 cpu_hit;
  logic                 force_slot;

  assign cpu_hit    = (cpu_address >= ADDR_W'(CPU_BASE));
  assign force_slot = per_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Owner decision and RAM port steering; idle leaves processor values on the bus.
  always_comb begin
    owner       = OWN_IDLE;
    per_gnt     = 1'b0;
    cpu_hold    = 1'b0;
    mem_wren    = 1'b0;
    mem_address = cpu_address;
    mem_data    = cpu_data;
    if (force_slot) begin
      owner       = OWN_PER;
      per_gnt     = 1'b1;
      cpu_hold    = cpu_hit;
      mem_wren    = per_wren;
      mem_address = per_address;
      mem_data    = per_data;
    end else if (cpu_hit) begin
      owner    = OWN_CPU;
      mem_wren = cpu_wren;
    end else if (per_req) begin
      owner       = OWN_PER;
      per_gnt     = 1'b1;
      mem_wren    = per_wren;
      mem_address = per_address;
      mem_data    = per_data;
    end
  end

  // Next state: starvation counter, read-return tag, stall counter.
  always_comb begin
    starve_nxt = '0;
    rtag_nxt   = RTAG_NONE;
    stall_nxt  = stall_count;
    if (per_req && !per_gnt && (starve_cnt < CNT_W'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
    if (owner == OWN_PER && !per_wren) begin
      rtag_nxt = RTAG_PER;
    end else if (owner == OWN_CPU && !cpu_wren) begin
      rtag_nxt = RTAG_CPU;
    end
    if (cpu_hold && (stall_count != STALL_SAT)) begin
      stall_nxt = stall_count + STALL_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      starve_cnt  <= '0;
      rtag        <= RTAG_NONE;
      stall_count <= '0;
    end else begin
      starve_cnt  <= starve_nxt;
      rtag        <= rtag_nxt;
      stall_count <= stall_nxt;
    end
  end

  // Read data is steered to whichever requester issued last cycle's read.
  assign per_rvalid = (rtag == RTAG_PER);
  assign per_q      = per_rvalid ? mem_q : '0;
  assign cpu_q      = (rtag == RTAG_CPU) ? mem_q : '0;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench for vmem_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_vmem_arbiter;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CPU_BASE   = 5000;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned MEM_DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_wren = 1'b0;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_hold;
  logic              per_req = 1'b0;
  logic              per_wren = 1'b0;
  logic [ADDR_W-1:0] per_address = '0;
  logic [DATA_W-1:0] per_data = '0;
  logic              per_gnt;
  logic              per_rvalid;
  logic [DATA_W-1:0] per_q;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem_q = '0;
  logic [15:0]       stall_count;

  // Second instance with the tightest starvation bound, used for saturation.
  logic              s_rst = 1'b1;
  logic [DATA_W-1:0] s_cpu_q;
  logic              s_cpu_hold;
  logic              s_per_gnt;
  logic              s_per_rvalid;
  logic [DATA_W-1:0] s_per_q;
  logic              s_mem_wren;
  logic [ADDR_W-1:0] s_mem_address;
  logic [DATA_W-1:0] s_mem_data;
  logic [DATA_W-1:0] s_mem_q = '0;
  logic [15:0]       s_stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_BASE(CPU_BASE),
                 .STARVE_MAX(STARVE_MAX)) dut (
    .system_clock(clk), .reset(rst),
    .cpu_wren(cpu_wren), .cpu_address(cpu_address), .cpu_data(cpu_data),
    .cpu_q(cpu_q), .cpu_hold(cpu_hold),
    .per_req(per_req), .per_wren(per_wren), .per_address(per_address),
    .per_data(per_data), .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_q(per_q),
    .mem_wren(mem_wren), .mem_address(mem_address), .mem_data(mem_data),
    .mem_q(mem_q), .stall_count(stall_count)
  );

  vmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_BASE(CPU_BASE),
                 .STARVE_MAX(1)) s_dut (
    .system_clock(clk), .reset(s_rst),
    .cpu_wren(1'b0), .cpu_address(17'd5500), .cpu_data(32'd0),
    .cpu_q(s_cpu_q), .cpu_hold(s_cpu_hold),
    .per_req(1'b1), .per_wren(1'b0), .per_address(17'd5001),
    .per_data(32'd0), .per_gnt(s_per_gnt), .per_rvalid(s_per_rvalid), .per_q(s_per_q),
    .mem_wren(s_mem_wren), .mem_address(s_mem_address), .mem_data(s_mem_data),
    .mem_q(s_mem_q), .stall_count(s_stall_count)
  );

  // Synchronous RAM seen by the DUT.
  bit [DATA_W-1:0] ram [0:MEM_DEPTH-1];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  // Behavioural model: denied-cycle count, pending return, stall total, shadow memory.
  int              m_wait = 0;
  int              m_ret  = 0;   // 0 none, 1 processor, 2 peripheral
  logic [DATA_W-1:0] m_ret_data = '0;
  int              m_stall = 0;
  bit [DATA_W-1:0] m_mem [0:MEM_DEPTH-1];

  function automatic bit f_hit();
    return int'(cpu_address) >= int'(CPU_BASE);
  endfunction
  function automatic bit f_force();
    return per_req && (m_wait == int'(STARVE_MAX));
  endfunction
  function automatic bit f_gnt();
    return f_force() || (per_req && !f_hit());
  endfunction
  function automatic bit f_cpu_owns();
    return f_hit() && !f_force();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait     <= 0;
      m_ret      <= 0;
      m_ret_data <= '0;
      m_stall    <= 0;
    end else begin
      m_wait <= (per_req && !f_gnt()) ? m_wait + 1 : 0;
      if (f_gnt() && !per_wren) begin
        m_ret <= 2; m_ret_data <= m_mem[int'(per_address)];
      end else if (f_cpu_owns() && !cpu_wren) begin
        m_ret <= 1; m_ret_data <= m_mem[int'(cpu_address)];
      end else begin
        m_ret <= 0; m_ret_data <= '0;
      end
      if (f_gnt() && per_wren) m_mem[int'(per_address)] <= per_data;
      else if (f_cpu_owns() && cpu_wren) m_mem[int'(cpu_address)] <= cpu_data;
      if (f_force() && f_hit() && m_stall < 65535) m_stall <= m_stall + 1;
    end
  end

  // Apply one cycle of inputs after the falling edge and settle.
  task automatic drive(input logic cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                       input logic pr, input logic pw, input logic [ADDR_W-1:0] pa,
                       input logic [DATA_W-1:0] pd);
    @(negedge clk);
    cpu_wren = cw; cpu_address = ca; cpu_data = cd;
    per_req = pr; per_wren = pw; per_address = pa; per_data = pd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) idle();
    total++; if (per_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", per_rvalid); end
    total++; if (per_q !== '0) begin bad++; $display("FAIL reset_per_q: got %h want 0", per_q); end
    total++; if (cpu_q !== '0) begin bad++; $display("FAIL reset_cpu_q: got %h want 0", cpu_q); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
    total++; if (per_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0", per_gnt); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", cpu_hold); end
    total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_starvation();
    logic        eg;
    logic [15:0] es;
    idle();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 17'd5500, '0, 1'b1, 1'b0, 17'd5001, '0);
      eg = (k == 5);
      es = (k == 6) ? 16'd1 : 16'd0;
      total++; if (per_gnt !== eg) begin bad++; $display("FAIL starve_gnt c%0d: got %b want %b", k, per_gnt, eg); end
      total++; if (cpu_hold !== eg) begin bad++; $display("FAIL starve_hold c%0d: got %b want %b", k, cpu_hold, eg); end
      total++; if (stall_count !== es) begin bad++; $display("FAIL starve_stall c%0d: got %0d want %0d", k, stall_count, es); end
    end
    idle();
    idle();
  endtask

  task automatic test_unopposed_read();
    drive(1'b1, 17'd6000, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    total++; if (mem_wren !== 1'b1 || mem_address !== 17'd6000 || mem_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL cpu_write: got wren=%b addr=%0d data=%h want 1/6000/deadbeef", mem_wren, mem_address, mem_data); end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 17'd6000, '0);
    total++; if (per_gnt !== 1'b1) begin bad++; $display("FAIL unopp_gnt: got %b want 1", per_gnt); end
    total++; if (mem_address !== 17'd6000 || mem_wren !== 1'b0) begin
      bad++; $display("FAIL unopp_addr: got addr=%0d wren=%b want 6000/0", mem_address, mem_wren); end
    idle();
    total++; if (per_rvalid !== 1'b1 || per_q !== 32'hDEADBEEF) begin
      bad++; $display("FAIL unopp_ret: got rvalid=%b q=%h want 1/deadbeef", per_rvalid, per_q); end
    total++; if (cpu_q !== '0) begin bad++; $display("FAIL unopp_cpu_q: got %h want 0", cpu_q); end
    idle();
    total++; if (per_rvalid !== 1'b0) begin bad++; $display("FAIL unopp_done: got %b want 0", per_rvalid); end
  endtask

  task automatic test_below_base();
    drive(1'b1, 17'd100, 32'h1234, 1'b0, 1'b0, '0, '0);
    total++; if (mem_wren !== 1'b0 || per_gnt !== 1'b0) begin
      bad++; $display("FAIL below_idle: got wren=%b gnt=%b want 0/0", mem_wren, per_gnt); end
    drive(1'b1, 17'd100, 32'h1234, 1'b1, 1'b0, 17'd6000, '0);
    total++; if (mem_wren !== 1'b0 || per_gnt !== 1'b1 || mem_address !== 17'd6000) begin
      bad++; $display("FAIL below_gnt: got wren=%b gnt=%b addr=%0d want 0/1/6000", mem_wren, per_gnt, mem_address); end
    drive(1'b0, 17'd6000, '0, 1'b0, 1'b0, '0, '0);
    total++; if (per_rvalid !== 1'b1 || per_q !== 32'hDEADBEEF) begin
      bad++; $display("FAIL below_ret: got rvalid=%b q=%h want 1/deadbeef", per_rvalid, per_q); end
    idle();
    total++; if (cpu_q !== 32'hDEADBEEF || per_rvalid !== 1'b0) begin
      bad++; $display("FAIL cpu_read_ret: got cpu_q=%h rvalid=%b want deadbeef/0", cpu_q, per_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] vals [3];
    logic              erv;
    for (int i = 0; i < 3; i++) begin
      vals[i] = $urandom;
      drive(1'b1, ADDR_W'(5000 + i), vals[i], 1'b0, 1'b0, '0, '0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, (i < 3), 1'b0, ADDR_W'(5000 + i), '0);
      erv = (i >= 1 && i <= 3);
      total++; if (per_gnt !== logic'(i < 3)) begin bad++; $display("FAIL b2b_gnt%0d: got %b want %b", i, per_gnt, i < 3); end
      total++; if (per_rvalid !== erv) begin bad++; $display("FAIL b2b_rvalid%0d: got %b want %b", i, per_rvalid, erv); end
      if (erv) begin
        total++; if (per_q !== vals[i-1]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, per_q, vals[i-1]); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 17'd5001, '0);
    total++; if (per_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt: got %b want 1", per_gnt); end
    @(negedge clk);
    rst = 1'b1; per_req = 1'b0;
    #1;
    total++; if (per_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rvalid: got %b want 0", per_rvalid); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rmid_stall: got %0d want 0", stall_count); end
    total++; if (dut.starve_cnt !== 4'd0) begin bad++; $display("FAIL rmid_starve: got %0d want 0", dut.starve_cnt); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    total++; if (per_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_after: got %b want 0", per_rvalid); end
  endtask

  task automatic test_random();
    bit                pending = 0;
    logic              pw = 0;
    logic [ADDR_W-1:0] pa = '0;
    logic [DATA_W-1:0] pd = '0;
    logic              prev_gnt = 0;
    logic              cw;
    logic [ADDR_W-1:0] ca;
    logic              eg, eh, ew, erv;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed, epq, ecq;
    for (int i = 0; i < 600; i++) begin
      if (prev_gnt) pending = 0;
      if (pending && $urandom_range(0, 15) == 0) pending = 0;
      if (!pending && $urandom_range(0, 2) == 0) begin
        pending = 1;
        pw = logic'($urandom_range(0, 1));
        pa = ADDR_W'(5000 + $urandom_range(0, 31));
        pd = $urandom;
      end
      cw = logic'($urandom_range(0, 1));
      ca = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 4999))
                                        : ADDR_W'(5000 + $urandom_range(0, 31));
      drive(cw, ca, $urandom, pending, pw, pa, pd);
      eg  = f_gnt();
      eh  = f_force() && f_hit();
      ew  = f_cpu_owns() ? cpu_wren : (eg ? per_wren : 1'b0);
      ea  = eg ? per_address : cpu_address;
      ed  = eg ? per_data : cpu_data;
      erv = (m_ret == 2);
      epq = erv ? m_ret_data : '0;
      ecq = (m_ret == 1) ? m_ret_data : '0;
      total++; if (per_gnt !== eg) begin bad++; $display("FAIL rnd_gnt i%0d: got %b want %b", i, per_gnt, eg); end
      total++; if (cpu_hold !== eh) begin bad++; $display("FAIL rnd_hold i%0d: got %b want %b", i, cpu_hold, eh); end
      total++; if (mem_wren !== ew) begin bad++; $display("FAIL rnd_wren i%0d: got %b want %b", i, mem_wren, ew); end
      total++; if (mem_address !== ea || mem_data !== ed) begin
        bad++; $display("FAIL rnd_bus i%0d: got %0d/%h want %0d/%h", i, mem_address, mem_data, ea, ed); end
      total++; if (per_rvalid !== erv || per_q !== epq) begin
        bad++; $display("FAIL rnd_per_ret i%0d: got %b/%h want %b/%h", i, per_rvalid, per_q, erv, epq); end
      total++; if (cpu_q !== ecq) begin bad++; $display("FAIL rnd_cpu_q i%0d: got %h want %h", i, cpu_q, ecq); end
      total++; if (stall_count !== 16'(m_stall)) begin
        bad++; $display("FAIL rnd_stall i%0d: got %0d want %0d", i, stall_count, m_stall); end
      prev_gnt = per_gnt;
    end
    idle();
  endtask

  task automatic test_saturation();
    int exp_stall;
    @(negedge clk);
    s_rst = 1'b0;
    for (int c = 1; c <= 131080; c++) begin
      @(negedge clk);
      exp_stall = (c / 2 > 65535) ? 65535 : c / 2;
      if (c == 3 || c == 4) begin
        total++; if (s_cpu_hold !== logic'(c % 2) || s_per_gnt !== logic'(c % 2)) begin
          bad++; $display("FAIL sat_hold c%0d: got hold=%b gnt=%b want %0d", c, s_cpu_hold, s_per_gnt, c % 2); end
      end
      if (c == 10 || c == 131069 || c == 131070 || c == 131080) begin
        total++; if (s_stall_count !== 16'(exp_stall)) begin
          bad++; $display("FAIL sat_stall c%0d: got %0d want %0d", c, s_stall_count, exp_stall); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_starvation();
    test_unopposed_read();
    test_below_base();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
